// File: rtl/dphy_pkg.sv
// Shared D-PHY HS definitions: lane FSM states and the leader byte values.
package dphy_pkg;

  localparam logic [7:0] DPHY_SYNC_BYTE    = 8'hB8;
  localparam logic [7:0] DPHY_HS_ZERO_BYTE = 8'h00;

  typedef enum logic [2:0] {
    IDLE, HS_ZERO, SYNC, DATA, TRAIL, FLUSH
  } hs_tx_state_t;

endpackage

// File: rtl/dphy_hs_lane_tx_if.sv
// Payload byte stream into the HS lane transmitter.
interface dphy_hs_lane_tx_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (output s_data, s_valid, s_last, input s_ready);
  modport slave  (input s_data, s_valid, s_last, output s_ready);
endinterface

// File: rtl/dphy_bit_skew_shifter.sv
// Delays a byte stream by 0..7 bits: output is the byte window that starts skew bits into prev.
module dphy_bit_skew_shifter (
  input  logic [7:0] cur,
  input  logic [7:0] prev,
  input  logic [2:0] skew,
  output logic [7:0] out
);
  logic [3:0] sh;

  always_comb begin
    sh  = 4'd8 - {1'b0, skew};
    out = 8'({cur, prev} >> sh);
  end
endmodule

// File: rtl/dphy_hs_lane_tx.sv
// Byte-wide D-PHY HS lane transmitter: HS-zero, sync, payload, trailer, with programmable bit skew.
// Optional HS_TX_BYTE_COUNT_EN adds tx_byte_count (payload bytes accepted this burst).
module dphy_hs_lane_tx import dphy_pkg::*; #(
  parameter int unsigned HS_ZERO_BYTES = 4,
  parameter int unsigned TRAIL_BYTES   = 2,
  parameter logic [7:0]  SYNC_BYTE     = DPHY_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        skew,
  dphy_hs_lane_tx_if.slave  s,
  output logic [7:0]        tx_word,
  output logic              tx_hs_active,
  output logic              busy,
  output logic              done,
  output logic              err_underrun
`ifdef HS_TX_BYTE_COUNT_EN
  ,
  output logic [15:0]       tx_byte_count
`endif
);
  localparam logic [3:0] HZ_LOAD = 4'(HS_ZERO_BYTES - 1);
  localparam logic [3:0] TR_LOAD = 4'(TRAIL_BYTES - 1);

  hs_tx_state_t state;
  logic [2:0]   skew_q;
  logic [7:0]   prev_byte, cur, trailer, skewed;
  logic [3:0]   cnt;
  logic         last_b;   // bit7 of the last sync/payload byte sent

  assign trailer   = {8{~last_b}};
  assign busy      = (state != IDLE);
  assign s.s_ready = (state == DATA);

  always_comb begin
    cur = DPHY_HS_ZERO_BYTE;
    unique case (state)
      SYNC:         cur = SYNC_BYTE;
      DATA:         cur = s.s_valid ? s.s_data : trailer;
      TRAIL, FLUSH: cur = trailer;
      default:      cur = DPHY_HS_ZERO_BYTE;
    endcase
  end

  dphy_bit_skew_shifter u_skew (
    .cur  (cur),
    .prev (prev_byte),
    .skew (skew_q),
    .out  (skewed)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tx_word      <= 8'h00;
      tx_hs_active <= 1'b0;
      done         <= 1'b0;
      err_underrun <= 1'b0;
      skew_q       <= 3'd0;
      prev_byte    <= 8'h00;
      cnt          <= 4'd0;
      last_b       <= 1'b0;
    end else begin
      done         <= 1'b0;
      err_underrun <= 1'b0;
      tx_hs_active <= busy;
      // Idle keeps prev_byte zero so skewed leading bits of the next burst are HS-zero.
      tx_word      <= busy ? skewed : 8'h00;
      prev_byte    <= busy ? cur : 8'h00;
      case (state)
        IDLE: if (start) begin
          state  <= HS_ZERO;
          skew_q <= skew;
          cnt    <= HZ_LOAD;
        end
        HS_ZERO: if (cnt == 4'd0) state <= SYNC;
                 else cnt <= cnt - 4'd1;
        SYNC: begin
          last_b <= SYNC_BYTE[7];
          state  <= DATA;
        end
        DATA: begin
          cnt <= TR_LOAD;
          if (s.s_valid) begin
            last_b <= s.s_data[7];
            if (s.s_last) state <= TRAIL;
          end else begin
            err_underrun <= 1'b1;
            state        <= TRAIL;
          end
        end
        TRAIL: if (cnt == 4'd0) state <= FLUSH;
               else cnt <= cnt - 4'd1;
        FLUSH: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HS_TX_BYTE_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          tx_byte_count <= 16'd0;
    else if (state == IDLE && start)                  tx_byte_count <= 16'd0;
    else if (s.s_ready && s.s_valid && tx_byte_count != 16'hFFFF)
                                                      tx_byte_count <= tx_byte_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_dphy_hs_lane_tx.sv
// Self-checking bench for dphy_hs_lane_tx: bit-stream lane model plus directed literal checks.
module tb_dphy_hs_lane_tx;
  import dphy_pkg::*;

  localparam int H = 4;
  localparam int T = 2;

  logic       clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [2:0] skew = 3'd0;
  logic [7:0] tx_word;
  logic       tx_hs_active, busy, done, err_underrun;
`ifdef HS_TX_BYTE_COUNT_EN
  logic [15:0] tx_byte_count;
`endif

  dphy_hs_lane_tx_if sif ();

  dphy_hs_lane_tx #(.HS_ZERO_BYTES(H), .TRAIL_BYTES(T), .SYNC_BYTE(8'hB8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .skew         (skew),
    .s            (sif),
    .tx_word      (tx_word),
    .tx_hs_active (tx_hs_active),
    .busy         (busy),
    .done         (done),
    .err_underrun (err_underrun)
`ifdef HS_TX_BYTE_COUNT_EN
    ,
    .tx_byte_count(tx_byte_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic v; logic [7:0] d; logic l; } src_t;

  int          cyc = 0, checks = 0, errors = 0, busy_until = -1;
  logic [12:0] exp_v[int];          // {tx_word, hs_active, done, err, busy, s_ready}
  logic [7:0]  log_tx[int];
  logic        log_hs[int], log_done[int], log_err[int];
  src_t        src_q[$];

  initial forever begin @(posedge clk); cyc = cyc + 1; end

  // Payload source: presents queue head, pops it when the DUT was ready during that cycle.
  initial begin
    logic rdy_s;
    sif.s_valid = 1'b0; sif.s_data = 8'h00; sif.s_last = 1'b0;
    forever begin
      @(negedge clk); rdy_s = sif.s_ready;
      @(posedge clk);
      if (rdy_s && src_q.size() > 0) void'(src_q.pop_front());
      #2;
      if (src_q.size() > 0) begin
        sif.s_valid = src_q[0].v; sif.s_data = src_q[0].d; sif.s_last = src_q[0].l;
      end else begin
        sif.s_valid = 1'b0; sif.s_data = 8'h00; sif.s_last = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model; cycles the model does not cover must look idle.
  initial forever begin
    logic [12:0] act, e;
    @(negedge clk);
    act = {tx_word, tx_hs_active, done, err_underrun, busy, sif.s_ready};
    e   = exp_v.exists(cyc) ? exp_v[cyc] : 13'd0;
    log_tx[cyc] = tx_word; log_hs[cyc] = tx_hs_active;
    log_done[cyc] = done;  log_err[cyc] = err_underrun;
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL lane cycle %0d: got tx=%h hs/done/err/busy/rdy=%b, expected tx=%h %b",
               cyc, act[12:5], act[4:0], e[12:5], e[4:0]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Lane model: build the burst byte list, serialize LSB first, delay by sk bits, re-byte.
  task automatic model_burst(input int a, input logic [2:0] sk, input logic [7:0] p[$], input bit und);
    logic [7:0] b[$];
    logic [7:0] tr, ob;
    logic       l7;
    int         L, nd, idx, c;
    for (int i = 0; i < H; i++) b.push_back(8'h00);
    b.push_back(DPHY_SYNC_BYTE);
    l7 = DPHY_SYNC_BYTE[7];
    foreach (p[i]) begin b.push_back(p[i]); l7 = p[i][7]; end
    tr = l7 ? 8'h00 : 8'hFF;
    if (und) b.push_back(tr);
    for (int i = 0; i <= T; i++) b.push_back(tr);
    L  = b.size();
    nd = p.size() + (und ? 1 : 0);
    exp_v[a] = {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < L; i++) begin
      for (int k = 0; k < 8; k++) begin
        idx   = 8 * i + k - int'(sk);
        ob[k] = (idx < 0) ? 1'b0 : b[idx / 8][idx % 8];
      end
      c = a + 1 + i;
      exp_v[c] = {ob, 1'b1, (i == L - 1), (und && i == H + 1 + p.size()),
                  (i < L - 1), (c >= a + H + 1 && c <= a + H + nd)};
    end
    busy_until = a + L;
  endtask

  // Call at posedge+#1; returns acceptance edge, or -1 when the DUT is expected to ignore it.
  task automatic launch(input logic [2:0] sk, input logic [7:0] p[$], input bit und, output int a);
    src_t e;
    start = 1'b1; skew = sk;
    a = cyc + 1;
    if (a > busy_until) begin
      model_burst(a, sk, p, und);
      foreach (p[i]) begin
        e.v = 1'b1; e.d = p[i]; e.l = !und && (i == p.size() - 1);
        src_q.push_back(e);
      end
      if (und) begin e.v = 1'b0; e.d = 8'h00; e.l = 1'b0; src_q.push_back(e); end
    end else a = -1;
    tick();
    start = 1'b0; skew = 3'd0;
  endtask

  task automatic wait_idle();
    while (cyc <= busy_until + 2) tick();
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] lit[$];
    int a, a2, n;

    #1 rst = 1'b1;
    repeat (2) tick();
    chk("reset_tx_word", tx_word, 8'h00);
    chk("reset_flags", {tx_hs_active, busy, done, err_underrun}, 4'b0000);
    rst = 1'b0;
    tick();

    // Basic burst
    pl = '{8'h12, 8'h34};
    launch(3'd0, pl, 1'b0, a);
    wait_idle();
    lit = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hB8, 8'h12, 8'h34, 8'hFF, 8'hFF, 8'hFF};
    foreach (lit[i]) chk($sformatf("basic_tx[%0d]", i), log_tx[a + 1 + i], lit[i]);
    n = 0;
    for (int c = a - 1; c <= a + 12; c++) n += int'(log_hs[c]);
    chk("basic_hs_len", n, 10);
    chk("basic_done_on_flush", {log_done[a + 9], log_done[a + 10]}, 2'b01);
    chk("basic_idle_after", log_tx[a + 11], 8'h00);

    // Skewed sync
    pl = '{8'h12};
    launch(3'd3, pl, 1'b0, a);
    chk("model_pin_skew_sync", exp_v[a + 5][12:5], 8'hC0);
    wait_idle();
    chk("skew3_sync", log_tx[a + 5], 8'hC0);
    chk("skew3_data", log_tx[a + 6], 8'h95);

    // Underrun after 0x80
    pl = '{8'h80};
    launch(3'd0, pl, 1'b1, a);
    wait_idle();
    chk("underrun_trailer", {log_tx[a + 7], log_tx[a + 8], log_tx[a + 9], log_tx[a + 10]}, 32'h0);
    n = 0;
    for (int c = a; c <= a + 12; c++) n += int'(log_err[c]);
    chk("underrun_pulse_count", n, 1);
    chk("underrun_pulse_pos", log_err[a + 7], 1'b1);

    // Skew drain
    pl = '{8'hFF};
    launch(3'd7, pl, 1'b0, a);
    chk("model_pin_skew7", exp_v[a + 7][12:5], 8'h7F);
    wait_idle();
    lit = '{8'h00, 8'hDC, 8'h7F, 8'h00, 8'h00, 8'h00};
    foreach (lit[i]) chk($sformatf("skew7_tx[%0d]", i), log_tx[a + 5 + i], lit[i]);
    chk("skew7_idle_hs", {log_hs[a + 9], log_hs[a + 10]}, 2'b10);

    // start mid-burst is ignored (model expects no relaunch)
    pl = '{8'h01, 8'h02, 8'h03};
    launch(3'd1, pl, 1'b0, a);
    tick(); tick();
    pl = '{8'hAA};
    launch(3'd5, pl, 1'b0, a2);
    wait_idle();

    // start in the done cycle launches back-to-back
    pl = '{8'h55};
    launch(3'd0, pl, 1'b0, a);
    while (cyc < busy_until) tick();
    chk("b2b_done_seen", done, 1'b1);
    pl = '{8'h66};
    launch(3'd0, pl, 1'b0, a2);
    wait_idle();
    chk("b2b_second_sync", log_tx[a2 + 5], 8'hB8);
    chk("b2b_second_data", log_tx[a2 + 6], 8'h66);

    // Reset during DATA
    pl = '{8'h11, 8'h22, 8'h33};
    launch(3'd2, pl, 1'b0, a);
    while (cyc < a + H + 2) tick();
    #2;
    rst = 1'b1;
    exp_v.delete(); src_q.delete(); busy_until = cyc;
    #1;
    chk("rst_mid_tx_word", tx_word, 8'h00);
    chk("rst_mid_busy", {busy, tx_hs_active, sif.s_ready}, 3'b000);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Long burst with random payload
    pl.delete();
    for (int i = 0; i < 300; i++) pl.push_back(8'($urandom_range(0, 255)));
    launch(3'd2, pl, 1'b0, a);
    while (cyc < busy_until) tick();
`ifdef HS_TX_BYTE_COUNT_EN
    chk("byte_count_at_done", tx_byte_count, 16'd300);
    tick(); tick(); tick();
    chk("byte_count_held", tx_byte_count, 16'd300);
    pl = '{8'h42};
    launch(3'd0, pl, 1'b0, a2);
    chk("byte_count_cleared", tx_byte_count, 16'd0);
`endif
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
